i2c_req_arbiter: RTL and testbench

Round-robin scheduler that shares a single I2C master driver (the `i2c_dri` byte engine) among up to N requesters, such as TMP75 pollers and config writers. It latches the winning requester's write bytes and byte counts, launches the driver, and tracks its busy flag to completion. It then returns the read bytes with a one-cycle done pulse to the winner. It sits between the sensor-level sequencers and the driver instance in the top level.

---
 rtl/i2c_arb_pkg.sv | 13 +
 rtl/i2c_req_arbiter_rr_pick.sv | 30 +++
 rtl/i2c_req_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_i2c_req_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared state encoding and defaults for the I2C request arbiter.
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  localparam logic [31:0] DEFAULT_TIMEOUT = 32'd200000;

endpackage

// File: rtl/i2c_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward from ptr+1.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [IW-1:0] pos;

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    pos    = '0;
    for (int k = 1; k <= N; k++) begin
      pos = IW'((int'(ptr) + k) % N);
      if (!valid && req[pos]) begin
        valid       = 1'b1;
        onehot[pos] = 1'b1;
        idx         = pos;
      end
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin sharing of one i2c_dri byte engine among N_REQ requesters.
// Optional watchdog abort is built when I2C_ARB_TIMEOUT_EN is defined.
module i2c_req_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int          N_REQ    = 4,
  parameter int          WMEN_LEN = 3,
  parameter int          RMEN_LEN = 2,
  parameter logic [31:0] TIMEOUT  = DEFAULT_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*WMEN_LEN*8-1:0] req_wr_data,
  input  logic [N_REQ*8-1:0]         req_wr_cnt,
  input  logic [N_REQ*8-1:0]         req_rd_cnt,
  output logic [N_REQ-1:0]           gnt,
  output logic [N_REQ-1:0]           done,
  output logic                       err,
  output logic [RMEN_LEN*8-1:0]      rd_data,
  output logic [WMEN_LEN*8-1:0]      drv_wr_data,
  output logic [7:0]                 drv_wr_cnt,
  output logic [7:0]                 drv_rd_cnt,
  output logic                       drv_en,
  input  logic                       drv_busy,
  input  logic [RMEN_LEN*8-1:0]      drv_rd_data
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int WW    = WMEN_LEN * 8;
  localparam int RW    = RMEN_LEN * 8;

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT == 32'd0) begin : g_param_check
    $error("i2c_req_arbiter: unsupported parameter set");
  end

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] pick_idx;
  logic [N_REQ-1:0] pick_onehot;
  logic             pick_valid;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [RW-1:0]    rd_data_q, rd_data_d;
  logic [WW-1:0]    wr_data_q, wr_data_d;
  logic [7:0]       wr_cnt_q, wr_cnt_d;
  logic [7:0]       rd_cnt_q, rd_cnt_d;
  logic             en_q, en_d;

`ifdef I2C_ARB_TIMEOUT_EN
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        tmo_q, tmo_d;
  logic        err_q, err_d;
`endif

  rr_pick #(
    .N  (N_REQ),
    .IW (IDX_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    rd_data_d = rd_data_q;
    wr_data_d = wr_data_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    en_d      = en_q;
`ifdef I2C_ARB_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    tmo_d     = tmo_q;
    err_d     = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (!drv_busy && pick_valid) begin
          gnt_d = pick_onehot;
          idx_d = pick_idx;
          for (int i = 0; i < N_REQ; i++) begin
            if (pick_onehot[i]) begin
              wr_data_d = req_wr_data[i*WW +: WW];
              wr_cnt_d  = req_wr_cnt[i*8 +: 8];
              rd_cnt_d  = req_rd_cnt[i*8 +: 8];
            end
          end
          en_d    = 1'b1;
          state_d = LAUNCH;
`ifdef I2C_ARB_TIMEOUT_EN
          tmo_cnt_d = '0;
          tmo_d     = 1'b0;
`endif
        end
      end
      LAUNCH: begin
        if (drv_busy) begin
          en_d    = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!drv_busy) begin
          rd_data_d = drv_rd_data;
          state_d   = DONE;
        end
      end
      DONE: begin
        done_d  = gnt_q;
        gnt_d   = '0;
        ptr_d   = idx_q;
        state_d = IDLE;
`ifdef I2C_ARB_TIMEOUT_EN
        err_d = tmo_q;
`endif
      end
      default: state_d = IDLE;
    endcase

`ifdef I2C_ARB_TIMEOUT_EN
    // Watchdog overrides the normal LAUNCH/RUN progress when it expires
    if (state_q == LAUNCH || state_q == RUN) begin
      tmo_cnt_d = tmo_cnt_q + 32'd1;
      if (tmo_cnt_q >= TIMEOUT - 32'd1) begin
        en_d      = 1'b0;
        rd_data_d = '0;
        tmo_d     = 1'b1;
        state_d   = DONE;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= IDX_W'(N_REQ - 1);
      idx_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      rd_data_q <= '0;
      wr_data_q <= '0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      en_q      <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      rd_data_q <= rd_data_d;
      wr_data_q <= wr_data_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      en_q      <= en_d;
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign rd_data     = rd_data_q;
  assign drv_wr_data = wr_data_q;
  assign drv_wr_cnt  = wr_cnt_q;
  assign drv_rd_cnt  = rd_cnt_q;
  assign drv_en      = en_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Self-checking bench for i2c_req_arbiter with a behavioural driver and round-robin model.
`timescale 1ns/1ps
module tb_i2c_req_arbiter;

  localparam int N_REQ    = 4;
  localparam int WMEN_LEN = 3;
  localparam int RMEN_LEN = 2;
  localparam int WW       = WMEN_LEN * 8;
  localparam int RW       = RMEN_LEN * 8;
`ifdef I2C_ARB_TIMEOUT_EN
  localparam logic [31:0] TB_TIMEOUT = 32'd1000;
`else
  localparam logic [31:0] TB_TIMEOUT = 32'd200000;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*WW-1:0]     req_wr_data;
  logic [N_REQ*8-1:0]      req_wr_cnt;
  logic [N_REQ*8-1:0]      req_rd_cnt;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        done;
  logic                    err;
  logic [RW-1:0]           rd_data;
  logic [WW-1:0]           drv_wr_data;
  logic [7:0]              drv_wr_cnt;
  logic [7:0]              drv_rd_cnt;
  logic                    drv_en;
  logic                    drv_busy;
  logic [RW-1:0]           drv_rd_data;

  int   busy_left = 0;
  int   busy_len;
  bit   never_busy;
  logic ext_busy;
  time  fall_time;

  int checks;
  int errors;
  int last_served;
  logic [WW-1:0] exp_wd [N_REQ];
  logic [7:0]    exp_wc [N_REQ];
  logic [7:0]    exp_rc [N_REQ];

  i2c_req_arbiter #(
    .N_REQ    (N_REQ),
    .WMEN_LEN (WMEN_LEN),
    .RMEN_LEN (RMEN_LEN),
    .TIMEOUT  (TB_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_wr_data (req_wr_data),
    .req_wr_cnt  (req_wr_cnt),
    .req_rd_cnt  (req_rd_cnt),
    .gnt         (gnt),
    .done        (done),
    .err         (err),
    .rd_data     (rd_data),
    .drv_wr_data (drv_wr_data),
    .drv_wr_cnt  (drv_wr_cnt),
    .drv_rd_cnt  (drv_rd_cnt),
    .drv_en      (drv_en),
    .drv_busy    (drv_busy),
    .drv_rd_data (drv_rd_data)
  );

  always #5 clk = ~clk;

  assign drv_busy = (busy_left > 0) | ext_busy;

  // Driver stand-in: busy for busy_len cycles after it sees iic_en, ignores the arbiter reset
  always @(posedge clk) begin
    if (busy_left > 0) begin
      if (busy_left == 1) fall_time = $time;
      busy_left <= busy_left - 1;
    end else if (drv_en && !never_busy) begin
      busy_left <= busy_len;
    end
  end

  function automatic int model_pick(input logic [N_REQ-1:0] r, input int last);
    model_pick = -1;
    for (int k = 1; k <= N_REQ; k++) begin
      if (model_pick < 0 && r[(last + k) % N_REQ]) model_pick = (last + k) % N_REQ;
    end
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input int i, input logic [WW-1:0] wd,
                                input logic [7:0] wc, input logic [7:0] rc);
    req_wr_data[i*WW +: WW] = wd;
    req_wr_cnt[i*8 +: 8]    = wc;
    req_rd_cnt[i*8 +: 8]    = rc;
    exp_wd[i] = wd;
    exp_wc[i] = wc;
    exp_rc[i] = rc;
    req[i]    = 1'b1;
  endtask

  task automatic do_reset();
    int n;
    rst_n = 1'b0;
    req   = '0;
    ext_busy = 1'b0;
    n = 0;
    while (busy_left > 0 && n < 500) begin @(negedge clk); n++; end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    last_served = N_REQ - 1;
  endtask

  // One full transaction as seen by the model-chosen winner
  task automatic serve(input bit drop, input bit mid_change, input logic [RW-1:0] rdv,
                       output int gwait);
    int exp_i;
    int n;
    bit multi;
    logic [WW-1:0] ewd;
    exp_i = model_pick(req, last_served);
    gwait = 0;
    while (gnt == '0 && gwait < 400) begin @(negedge clk); gwait++; end
    check_output("gnt_onehot", 32'(gnt), 32'(1) << exp_i);
    check_output("drv_en_rise", 32'(drv_en), 32'd1);
    check_output("drv_wr_data", 32'(drv_wr_data), 32'(exp_wd[exp_i]));
    check_output("drv_cnts", {16'd0, drv_wr_cnt, drv_rd_cnt}, {16'd0, exp_wc[exp_i], exp_rc[exp_i]});
    ewd = exp_wd[exp_i];
    drv_rd_data = rdv;
    if (mid_change) begin
      req_wr_data[exp_i*WW +: WW] = ~ewd;
      req[exp_i] = 1'b0;
    end
    n = 0;
    multi = 1'b0;
    while (done == '0 && n < 800) begin
      @(negedge clk);
      n++;
      if ($countones(gnt) > 1) multi = 1'b1;
    end
    check_output("done_onehot", 32'(done), 32'(1) << exp_i);
    check_output("err_clear", 32'(err), 32'd0);
    check_output("rd_data_done", 32'(rd_data), 32'(rdv));
    check_output("done_latency", 32'($time - fall_time), 32'd25);
    check_output("drv_en_low", 32'(drv_en), 32'd0);
    check_output("gnt_cleared", 32'(gnt), 32'd0);
    check_output("wr_data_held", 32'(drv_wr_data), 32'(ewd));
    check_output("single_gnt", 32'(multi), 32'd0);
    last_served = exp_i;
    if (drop) req[exp_i] = 1'b0;
    @(negedge clk);
    check_output("done_pulse", 32'(done), 32'd0);
    check_output("rd_data_hold", 32'(rd_data), 32'(rdv));
  endtask

  initial begin
    int gw;
    int n;
    logic [N_REQ-1:0] v;
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    req         = '0;
    req_wr_data = '0;
    req_wr_cnt  = '0;
    req_rd_cnt  = '0;
    drv_rd_data = '0;
    ext_busy    = 1'b0;
    never_busy  = 1'b0;
    busy_len    = 10;
    last_served = N_REQ - 1;

    #1;
    check_output("rst_gnt", 32'(gnt), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_err", 32'(err), 32'd0);
    check_output("rst_drv_en", 32'(drv_en), 32'd0);
    check_output("rst_rd_data", 32'(rd_data), 32'd0);
    check_output("rst_drv_wr_data", 32'(drv_wr_data), 32'd0);
    check_output("rst_drv_cnts", {16'd0, drv_wr_cnt, drv_rd_cnt}, 32'd0);
    do_reset();

    $display("[TB] single request");
    busy_len = 100;
    @(negedge clk);
    apply_stimulus(1, 24'hC0_5A_90, 8'd3, 8'd0);
    serve(1'b1, 1'b0, 16'h0000, gw);
    check_output("gnt_latency", 32'(gw), 32'd1);

    $display("[TB] contention");
    do_reset();
    busy_len = 7;
    for (int i = 0; i < N_REQ; i++) apply_stimulus(i, 24'($urandom), 8'd2, 8'd1);
    for (int t = 0; t < 5; t++) serve(1'b0, 1'b0, 16'($urandom), gw);
    check_output("rr_last_is_0", 32'(last_served), 32'd0);

    $display("[TB] read return");
    do_reset();
    busy_len = 20;
    @(negedge clk);
    apply_stimulus(2, 24'h48_01_A2, 8'd2, 8'd2);
    serve(1'b1, 1'b0, 16'h1A90, gw);
    repeat (6) @(negedge clk);
    check_output("rd_data_persist", 32'(rd_data), 32'h1A90);

    $display("[TB] busy at start");
    ext_busy = 1'b1;
    apply_stimulus(0, 24'h90_00_01, 8'd1, 8'd2);
    repeat (10) @(negedge clk);
    check_output("no_gnt_while_busy", 32'(gnt), 32'd0);
    ext_busy = 1'b0;
    serve(1'b1, 1'b0, 16'($urandom), gw);

    $display("[TB] mid-transaction request change");
    apply_stimulus(3, 24'h12_34_56, 8'd3, 8'd1);
    serve(1'b1, 1'b1, 16'($urandom), gw);

    $display("[TB] randomized rounds");
    for (int r = 0; r < 15; r++) begin
      busy_len = $urandom_range(2, 30);
      v = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
      for (int i = 0; i < N_REQ; i++) begin
        if (v[i]) apply_stimulus(i, 24'($urandom), 8'($urandom_range(1, 3)), 8'($urandom_range(0, 2)));
      end
      n = 0;
      while (req != '0 && n < 2 * N_REQ) begin
        serve(1'b1, ($urandom_range(0, 3) == 0), 16'($urandom), gw);
        n++;
      end
    end

    $display("[TB] driver never busy");
    do_reset();
    never_busy = 1'b1;
    @(negedge clk);
    apply_stimulus(0, 24'h90_11_22, 8'd1, 8'd0);
`ifdef I2C_ARB_TIMEOUT_EN
    n = 0;
    while (gnt == '0 && n < 10) begin @(negedge clk); n++; end
    n = 0;
    while (done == '0 && n < 1200) begin @(negedge clk); n++; end
    check_output("tmo_done", 32'(done), 32'd1);
    check_output("tmo_err", 32'(err), 32'd1);
    check_output("tmo_rd_data", 32'(rd_data), 32'd0);
    check_output("tmo_cycles", 32'(n >= int'(TB_TIMEOUT) && n <= int'(TB_TIMEOUT) + 2), 32'd1);
`else
    repeat (60) @(negedge clk);
    check_output("stuck_gnt", 32'(gnt), 32'd1);
    check_output("stuck_drv_en", 32'(drv_en), 32'd1);
    check_output("stuck_no_done", 32'(done), 32'd0);
`endif
    do_reset();
    never_busy = 1'b0;

    $display("[TB] reset mid-RUN");
    busy_len = 50;
    @(negedge clk);
    apply_stimulus(1, 24'h90_AB_CD, 8'd2, 8'd2);
    n = 0;
    while (busy_left == 0 && n < 20) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("rst_run_gnt", 32'(gnt), 32'd0);
    check_output("rst_run_drv_en", 32'(drv_en), 32'd0);
    check_output("rst_run_done", 32'(done), 32'd0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    last_served = N_REQ - 1;
    apply_stimulus(1, 24'h90_AB_CD, 8'd2, 8'd2);
    apply_stimulus(0, 24'h90_00_07, 8'd1, 8'd1);
    repeat (3) @(negedge clk);
    check_output("post_rst_wait_busy", 32'(gnt), 32'd0);
    busy_len = 5;
    serve(1'b1, 1'b0, 16'($urandom), gw);
    check_output("post_rst_first_0", 32'(last_served), 32'd0);
    serve(1'b1, 1'b0, 16'($urandom), gw);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
